// File: rtl/register_file_param.sv
// register_file_param: parametrised control/status register file.
// Each register is RW, read-only (mirrors hw_in) or W1C sticky status (set by hw_set).
// Reads come back after a configurable number of cycles. Bad accesses raise a one-cycle error strobe.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | accepting requests (ready=1)
// RD_WAIT | read in flight, cnt_q counts down to the read_valid cycle
module register_file_param #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    NUM_REGS     = 4,
  parameter int                    ADDR_WIDTH   = 2,
  parameter int                    READ_LATENCY = 1,
  parameter logic [63:0]           RO_MASK      = '0,
  parameter logic [63:0]           W1C_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           write_enable,
  input  logic                           read_enable,
  input  logic [ADDR_WIDTH-1:0]          address,
  input  logic [DATA_WIDTH-1:0]          write_data,
  input  logic [DATA_WIDTH/8-1:0]        write_strb,
  output logic [DATA_WIDTH-1:0]          read_data,
  output logic                           read_valid,
  output logic                           ready,
  output logic                           error,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);
  localparam logic [1:0] CNT_LOAD = 2'(READ_LATENCY - 1);

  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

  state_t state_q, state_d;
  logic [1:0] cnt_q;

  logic addr_ok, ro_hit;
  logic wr_acc, rd_acc, both_acc, rd_fire;
  logic [DATA_WIDTH-1:0] byte_mask, clear_bits, rd_mux;
  logic [DATA_WIDTH-1:0] snap_data;
  logic snap_err;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_val;

  // hw_in/hw_set slices of registers of the other kinds are don't-care by design
  logic unused_hw;
  assign unused_hw = ^{hw_in, hw_set};

  assign addr_ok  = {1'b0, address} < NUM_REGS_W;
  assign wr_acc   = ready && write_enable && !read_enable;
  assign rd_acc   = ready && read_enable && !write_enable;
  assign both_acc = ready && write_enable && read_enable;
  assign rd_fire  = (state_q == RD_WAIT) && (cnt_q == 2'd1);

  // expand byte strobes into a bit mask
  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < NB; b++) begin
      byte_mask[b*8 +: 8] = {8{write_strb[b]}};
    end
  end

  assign clear_bits = write_data & byte_mask;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign reg_val[i] = hw_in[i*DATA_WIDTH +: DATA_WIDTH];
    end else if (W1C_MASK[i]) begin : g_w1c
      logic sel;
      logic [DATA_WIDTH-1:0] q;
      assign sel = wr_acc && addr_ok && (address == ADDR_WIDTH'(i));
      // sticky status: a hardware set in the same cycle beats a software clear
      always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= hw_set[i*DATA_WIDTH +: DATA_WIDTH] | (q & ~(sel ? clear_bits : '0));
      end
      assign reg_val[i] = q;
    end else begin : g_rw
      logic sel;
      logic [DATA_WIDTH-1:0] q;
      assign sel = wr_acc && addr_ok && (address == ADDR_WIDTH'(i));
      // byte-masked software write
      always_ff @(posedge clk) begin
        if (reset)    q <= RESET_VALUE;
        else if (sel) q <= (q & ~byte_mask) | (write_data & byte_mask);
      end
      assign reg_val[i] = q;
    end
  end

  assign reg_out = reg_val;

  // read mux and RO lookup; out-of-range addresses match nothing and read as zero
  always_comb begin
    rd_mux = '0;
    ro_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (address == ADDR_WIDTH'(i)) begin
        rd_mux = reg_val[i];
        ro_hit = RO_MASK[i];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: only multi-cycle reads leave IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_acc && (READ_LATENCY > 1)) state_d = RD_WAIT;
      RD_WAIT: if (rd_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ready is held low for as long as reset is high
  always_comb begin
    ready = (state_q == IDLE) && !reset;
  end

  // read latency down-counter, terminal count at 1 so it lands on 0 with read_valid
  always_ff @(posedge clk) begin
    if (reset)                    cnt_q <= '0;
    else if (rd_acc)              cnt_q <= CNT_LOAD;
    else if (state_q == RD_WAIT)  cnt_q <= cnt_q - 2'd1;
  end

  // response path: read snapshot, read_valid/read_data and the error strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      read_valid <= 1'b0;
      error      <= 1'b0;
      read_data  <= '0;
      snap_data  <= '0;
      snap_err   <= 1'b0;
    end else begin
      read_valid <= 1'b0;
      error      <= 1'b0;
      if (both_acc || (wr_acc && (!addr_ok || ro_hit))) error <= 1'b1;
      if (rd_acc) begin
        if (READ_LATENCY == 1) begin
          read_valid <= 1'b1;
          read_data  <= rd_mux;
          error      <= !addr_ok;
        end else begin
          snap_data  <= rd_mux;
          snap_err   <= !addr_ok;
        end
      end
      if (rd_fire) begin
        read_valid <= 1'b1;
        read_data  <= snap_data;
        error      <= snap_err;
      end
    end
  end

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param with three configurations:
//   A: 4 regs, latency 1, reg2 W1C, reg3 RO
//   B: 3 regs, latency 3, all RW
//   C: 4 regs, latency 2, all RW
// Read expectations go into a scoreboard queue and are matched against read_valid.
module tb_register_file_param;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int LAT_C = 2;
  localparam logic [31:0] RV_B = 32'h5555_5555;
  localparam logic [31:0] RV_C = 32'hCAFE_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_a, we_a, re_a, rv_a, rdy_a, err_a;
  logic [1:0]   addr_a;
  logic [31:0]  wd_a, rd_a;
  logic [3:0]   strb_a;
  logic [127:0] hw_in_a, hw_set_a, reg_out_a;

  logic         reset_b, we_b, re_b, rv_b, rdy_b, err_b;
  logic [1:0]   addr_b;
  logic [31:0]  wd_b, rd_b;
  logic [3:0]   strb_b;
  logic [95:0]  hw_in_b, hw_set_b, reg_out_b;

  logic         reset_c, we_c, re_c, rv_c, rdy_c, err_c;
  logic [1:0]   addr_c;
  logic [31:0]  wd_c, rd_c;
  logic [3:0]   strb_c;
  logic [127:0] hw_in_c, hw_set_c, reg_out_c;

  register_file_param #(.DATA_WIDTH(32), .NUM_REGS(4), .ADDR_WIDTH(2), .READ_LATENCY(LAT_A),
                        .RO_MASK(64'h8), .W1C_MASK(64'h4), .RESET_VALUE(32'h0)) dut_a (
    .clk(clk), .reset(reset_a), .write_enable(we_a), .read_enable(re_a), .address(addr_a),
    .write_data(wd_a), .write_strb(strb_a), .read_data(rd_a), .read_valid(rv_a), .ready(rdy_a),
    .error(err_a), .hw_in(hw_in_a), .hw_set(hw_set_a), .reg_out(reg_out_a));

  register_file_param #(.DATA_WIDTH(32), .NUM_REGS(3), .ADDR_WIDTH(2), .READ_LATENCY(LAT_B),
                        .RO_MASK(64'h0), .W1C_MASK(64'h0), .RESET_VALUE(RV_B)) dut_b (
    .clk(clk), .reset(reset_b), .write_enable(we_b), .read_enable(re_b), .address(addr_b),
    .write_data(wd_b), .write_strb(strb_b), .read_data(rd_b), .read_valid(rv_b), .ready(rdy_b),
    .error(err_b), .hw_in(hw_in_b), .hw_set(hw_set_b), .reg_out(reg_out_b));

  register_file_param #(.DATA_WIDTH(32), .NUM_REGS(4), .ADDR_WIDTH(2), .READ_LATENCY(LAT_C),
                        .RO_MASK(64'h0), .W1C_MASK(64'h0), .RESET_VALUE(RV_C)) dut_c (
    .clk(clk), .reset(reset_c), .write_enable(we_c), .read_enable(re_c), .address(addr_c),
    .write_data(wd_c), .write_strb(strb_c), .read_data(rd_c), .read_valid(rv_c), .ready(rdy_c),
    .error(err_c), .hw_in(hw_in_c), .hw_set(hw_set_c), .reg_out(reg_out_c));

  typedef struct {
    int          dut;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_err    = 0;
  int  cyc      = 0;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rv(int d, logic v, logic [31:0] data, logic e);
    sb_t x;
    if (v === 1'b0) return;
    n_checks++;
    assert ((sb.size() != 0) && (sb[0].dut == d)) else begin
      n_err++;
      $error("FAIL unexpected_read_valid dut=%0d observed=%0b expected=0 cyc=%0d", d, v, cyc);
    end
    if ((sb.size() == 0) || (sb[0].dut != d)) return;
    x = sb.pop_front();
    chk($sformatf("read_data_d%0d", d), data, x.data);
    chk($sformatf("read_err_d%0d", d), e, x.err);
    chk($sformatf("read_cycle_d%0d", d), cyc, x.cyc);
  endtask

  // one clock; outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check_rv(0, rv_a, rd_a, err_a);
    check_rv(1, rv_b, rd_b, err_b);
    check_rv(2, rv_c, rd_c, err_c);
  endtask

  task automatic drive(int d, logic we, logic re, logic [1:0] a, logic [31:0] wd, logic [3:0] st);
    case (d)
      0:       begin we_a = we; re_a = re; addr_a = a; wd_a = wd; strb_a = st; end
      1:       begin we_b = we; re_b = re; addr_b = a; wd_b = wd; strb_b = st; end
      default: begin we_c = we; re_c = re; addr_c = a; wd_c = wd; strb_c = st; end
    endcase
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    drive(2, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
  endtask

  task automatic wr(int d, logic [1:0] a, logic [31:0] wd, logic [3:0] st);
    drive(d, 1'b1, 1'b0, a, wd, st);
    step();
    idle();
  endtask

  // issues a read; the response is expected lat cycles after the accept edge
  task automatic rd(int d, int lat, logic [1:0] a, logic [31:0] exp, logic exp_err);
    sb_t x;
    x.dut = d; x.data = exp; x.err = exp_err; x.cyc = cyc + lat;
    sb.push_back(x);
    drive(d, 1'b0, 1'b1, a, 32'h0, 4'h0);
    step();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
    idle();
    hw_in_a  = {32'h0000_5A5A, 32'h2222_2222, 32'h1111_1111, 32'hFFFF_FFFF};
    hw_set_a = '0;
    hw_in_b  = '0; hw_set_b = '0;
    hw_in_c  = '0; hw_set_c = '0;

    step();
    step();
    chk("reset_ready_a", rdy_a, 1'b0);
    chk("reset_ready_b", rdy_b, 1'b0);
    chk("reset_ready_c", rdy_c, 1'b0);
    chk("reset_rvalid_a", rv_a, 1'b0);
    chk("reset_error_a", err_a, 1'b0);
    chk("reset_rdata_a", rd_a, 32'h0);
    chk("reset_regs_a", reg_out_a, {32'h0000_5A5A, 96'h0});
    chk("reset_regs_b", reg_out_b, {RV_B, RV_B, RV_B});
    chk("reset_regs_c", reg_out_c, {RV_C, RV_C, RV_C, RV_C});

    reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
    step();
    chk("ready_after_reset_a", rdy_a, 1'b1);
    chk("ready_after_reset_b", rdy_b, 1'b1);
    chk("ready_after_reset_c", rdy_c, 1'b1);

    // A: full write then latency-1 read
    wr(0, 2'd1, 32'hDEAD_BEEF, 4'hF);
    chk("wr1_error_a", err_a, 1'b0);
    chk("wr1_reg1_a", reg_out_a[32 +: 32], 32'hDEAD_BEEF);
    rd(0, LAT_A, 2'd1, 32'hDEAD_BEEF, 1'b0);
    step();
    chk("rdata_hold_a", rd_a, 32'hDEAD_BEEF);

    // A: back-to-back writes, second one byte-strobed
    wr(0, 2'd0, 32'hDEAD_BEEF, 4'hF);
    chk("b2b_ready_a", rdy_a, 1'b1);
    wr(0, 2'd0, 32'h1122_3344, 4'b0101);
    chk("strb_reg0_a", reg_out_a[31:0], 32'hDE22_BE44);

    // A: zero-strobe write is a silent no-op
    wr(0, 2'd1, 32'hFFFF_FFFF, 4'h0);
    chk("zero_strb_err_a", err_a, 1'b0);
    chk("zero_strb_reg1_a", reg_out_a[32 +: 32], 32'hDEAD_BEEF);

    // A: W1C reg2, hw_set on RW reg0 must be ignored
    hw_set_a = {32'h0, 32'h0000_00F0, 32'h0, 32'hFFFF_0000};
    step();
    hw_set_a = '0;
    chk("w1c_set_a", reg_out_a[64 +: 32], 32'h0000_00F0);
    chk("hwset_rw_ignored_a", reg_out_a[31:0], 32'hDE22_BE44);
    wr(0, 2'd2, 32'h0000_0030, 4'hF);
    chk("w1c_clear_a", reg_out_a[64 +: 32], 32'h0000_00C0);
    hw_set_a = {32'h0, 32'h0000_0010, 64'h0};
    wr(0, 2'd2, 32'h0000_0010, 4'hF);
    hw_set_a = '0;
    chk("w1c_set_wins_a", reg_out_a[64 +: 32], 32'h0000_00D0);
    wr(0, 2'd2, 32'h0000_00FF, 4'b0010);
    chk("w1c_unstrobed_a", reg_out_a[64 +: 32], 32'h0000_00D0);
    wr(0, 2'd2, 32'h0000_0080, 4'b0001);
    chk("w1c_clear_bit7_a", reg_out_a[64 +: 32], 32'h0000_0050);
    rd(0, LAT_A, 2'd2, 32'h0000_0050, 1'b0);

    // A: RO reg3
    wr(0, 2'd3, 32'h0000_0001, 4'hF);
    chk("ro_write_err_a", err_a, 1'b1);
    chk("ro_write_reg3_a", reg_out_a[96 +: 32], 32'h0000_5A5A);
    step();
    chk("ro_err_one_cycle_a", err_a, 1'b0);
    rd(0, LAT_A, 2'd3, 32'h0000_5A5A, 1'b0);
    hw_in_a[96 +: 32] = 32'h0000_BEEF;
    #1;
    chk("ro_comb_reg_out_a", reg_out_a[96 +: 32], 32'h0000_BEEF);
    rd(0, LAT_A, 2'd3, 32'h0000_BEEF, 1'b0);

    // A: read and write together
    drive(0, 1'b1, 1'b1, 2'd1, 32'h0, 4'hF);
    step();
    idle();
    chk("rw_both_err_a", err_a, 1'b1);
    chk("rw_both_reg1_a", reg_out_a[32 +: 32], 32'hDEAD_BEEF);
    step();
    chk("rw_both_err_clear_a", err_a, 1'b0);

    // B: latency 3, write during RD_WAIT ignored
    wr(1, 2'd0, 32'h0000_0077, 4'b0001);
    chk("strb_reg0_b", reg_out_b[31:0], 32'h5555_5577);
    rd(1, LAT_B, 2'd0, 32'h5555_5577, 1'b0);
    chk("rdwait_ready1_b", rdy_b, 1'b0);
    drive(1, 1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF, 4'hF);
    step();
    idle();
    chk("rdwait_ready2_b", rdy_b, 1'b0);
    chk("ignored_wr_err_b", err_b, 1'b0);
    step();
    chk("ready_with_rvalid_b", rdy_b, 1'b1);
    step();
    chk("ignored_wr_reg0_b", reg_out_b[31:0], 32'h5555_5577);

    // B: out-of-range read and write
    rd(1, LAT_B, 2'd3, 32'h0, 1'b1);
    chk("oor_rd_no_early_err1_b", err_b, 1'b0);
    step();
    chk("oor_rd_no_early_err2_b", err_b, 1'b0);
    step();
    wr(1, 2'd3, 32'hFFFF_FFFF, 4'hF);
    chk("oor_wr_err_b", err_b, 1'b1);
    chk("oor_wr_regs_b", reg_out_b, {RV_B, RV_B, 32'h5555_5577});

    // C: reset one cycle after a latency-2 read accept drops that read
    wr(2, 2'd1, 32'h1234_5678, 4'hF);
    chk("wr_reg1_c", reg_out_c[32 +: 32], 32'h1234_5678);
    drive(2, 1'b0, 1'b1, 2'd1, 32'h0, 4'h0);
    step();
    idle();
    reset_c = 1'b1;
    #1;
    chk("mid_reset_ready_c", rdy_c, 1'b0);
    step();
    chk("mid_reset_no_rvalid_c", rv_c, 1'b0);
    chk("mid_reset_ready2_c", rdy_c, 1'b0);
    reset_c = 1'b0;
    step();
    chk("post_reset_ready_c", rdy_c, 1'b1);
    chk("post_reset_rvalid_c", rv_c, 1'b0);
    chk("post_reset_regs_c", reg_out_c, {RV_C, RV_C, RV_C, RV_C});
    step();
    chk("dropped_read_stays_c", rv_c, 1'b0);
    rd(2, LAT_C, 2'd2, RV_C, 1'b0);
    step();

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
